// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//
// Sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB, holding
// the instruction register, a sticky halt state and (optionally) an LL/SC
// link flag. All strobes are combinational from state + IR (+ hit inputs).
//
// Handshake: a request (iREN in FETCH, dREN/dWEN in MEM) is raised on entry
// to its state and held, together with every decoded field, until the
// matching hit (ihit/dhit) is seen high on a rising edge; that edge completes
// the transfer and leaves the state. A hit seen in any other state is ignored.
// An SC whose link is already lost raises no request and completes at once.
//
// Parameters:
//   LLSC_EN  1: decode LL/SC and keep the link flag; 0: LL/SC are illegal.
//   WORD_W   instruction width; field positions are the 32-bit MIPS ones.
// Ports:
//   CLK, nRST                  clock, async active-low reset
//   instruction, ihit          icache word and completion
//   dhit                       dcache completion
//   alu_zf                     ALU zero flag (branch resolve in EXEC)
//   link_clear                 coherence invalidate of the linked line
//   iREN, dREN, dWEN           memory requests
//   IRWr, PCWr, RegWr          one-cycle write strobes
//   opcode..immediate26        fields of the latched IR
//   MemToReg, RegDst, ALUSrc,
//   ExtOp, ALUctr, PCSrc       datapath selects
//   sc_success                 value SC writes to rt
//   link_valid, halt, state    link flag, sticky halt, debug state
//
// ALUctr encoding: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 XOR, 7 NOR,
//                  8 SLT, 9 SLTU, 10 SLL, 11 SRL.
module multicycle_control_unit #(
  parameter bit LLSC_EN = 1'b1,
  parameter int WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [WORD_W-1:0] instruction,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              alu_zf,
  input  logic              link_clear,
  output logic              iREN,
  output logic              dREN,
  output logic              dWEN,
  output logic              IRWr,
  output logic              PCWr,
  output logic              RegWr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [15:0]       immediate,
  output logic [25:0]       immediate26,
  output logic [1:0]        MemToReg,
  output logic [1:0]        RegDst,
  output logic [1:0]        ALUSrc,
  output logic              ExtOp,
  output logic [3:0]        ALUctr,
  output logic [2:0]        PCSrc,
  output logic              sc_success,
  output logic              link_valid,
  output logic              halt,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LL    = 6'h30;
  localparam logic [5:0] OP_SC    = 6'h38;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_ADDU = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SUBU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SRL  = 4'd11;

  localparam logic [2:0] PC_SEQ = 3'd0;
  localparam logic [2:0] PC_BR  = 3'd1;
  localparam logic [2:0] PC_J   = 3'd2;
  localparam logic [2:0] PC_JR  = 3'd3;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] ir;
  logic              link_q;
  logic              sc_armed;
  logic              legal;

  // ---------------------------------------------------------------- fields
  assign opcode      = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign shamt       = ir[10:6];
  assign funct       = ir[5:0];
  assign immediate   = ir[15:0];
  assign immediate26 = ir[25:0];

  assign state      = state_q;
  assign halt       = (state_q == S_HALT);
  assign link_valid = link_q;
  assign sc_success = sc_armed;

  // ------------------------------------------------------- class decode
  logic is_j, is_jr, is_jal, is_beq, is_bne, is_lw, is_sw, is_ll, is_sc;
  logic is_halt, is_mem, branch_taken, sc_done;

  assign is_j    = (opcode == OP_J);
  assign is_jr   = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign is_jal  = (opcode == OP_JAL);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_bne  = (opcode == OP_BNE);
  assign is_lw   = (opcode == OP_LW);
  assign is_sw   = (opcode == OP_SW);
  assign is_ll   = LLSC_EN && (opcode == OP_LL);
  assign is_sc   = LLSC_EN && (opcode == OP_SC);
  assign is_halt = (opcode == OP_HALT);
  assign is_mem  = is_lw || is_sw || is_ll || is_sc;

  assign branch_taken = (is_beq && alu_zf) || (is_bne && !alu_zf);
  // A failed SC never issues a store, so it finishes without waiting.
  assign sc_done      = !sc_armed || dhit;

  // Datapath selects depend only on IR, so they are stable for the whole
  // life of the instruction, including every wait cycle.
  always_comb begin
    legal    = 1'b0;
    ALUctr   = ALU_ADD;
    ALUSrc   = 2'd0;
    ExtOp    = 1'b0;
    RegDst   = 2'd0;
    MemToReg = 2'd0;
    case (opcode)
      OP_RTYPE: begin
        RegDst = 2'd1;
        legal  = 1'b1;
        case (funct)
          FN_ADD:  ALUctr = ALU_ADD;
          FN_ADDU: ALUctr = ALU_ADDU;
          FN_SUB:  ALUctr = ALU_SUB;
          FN_SUBU: ALUctr = ALU_SUBU;
          FN_AND:  ALUctr = ALU_AND;
          FN_OR:   ALUctr = ALU_OR;
          FN_XOR:  ALUctr = ALU_XOR;
          FN_NOR:  ALUctr = ALU_NOR;
          FN_SLT:  ALUctr = ALU_SLT;
          FN_SLTU: ALUctr = ALU_SLTU;
          FN_SLL:  begin ALUctr = ALU_SLL; ALUSrc = 2'd2; end
          FN_SRL:  begin ALUctr = ALU_SRL; ALUSrc = 2'd2; end
          FN_JR:   ALUctr = ALU_ADD;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDI:  begin legal = 1'b1; ALUctr = ALU_ADD;  ALUSrc = 2'd1; ExtOp = 1'b1; end
      OP_ADDIU: begin legal = 1'b1; ALUctr = ALU_ADDU; ALUSrc = 2'd1; ExtOp = 1'b1; end
      OP_SLTI:  begin legal = 1'b1; ALUctr = ALU_SLT;  ALUSrc = 2'd1; ExtOp = 1'b1; end
      OP_SLTIU: begin legal = 1'b1; ALUctr = ALU_SLTU; ALUSrc = 2'd1; ExtOp = 1'b1; end
      OP_ANDI:  begin legal = 1'b1; ALUctr = ALU_AND;  ALUSrc = 2'd1; end
      OP_ORI:   begin legal = 1'b1; ALUctr = ALU_OR;   ALUSrc = 2'd1; end
      OP_XORI:  begin legal = 1'b1; ALUctr = ALU_XOR;  ALUSrc = 2'd1; end
      OP_LUI:   begin legal = 1'b1; ALUSrc = 2'd1; MemToReg = 2'd3; end
      OP_BEQ,
      OP_BNE:   begin legal = 1'b1; ALUctr = ALU_SUB; ExtOp = 1'b1; end
      OP_LW:    begin legal = 1'b1; ALUSrc = 2'd1; ExtOp = 1'b1; MemToReg = 2'd1; end
      OP_SW:    begin legal = 1'b1; ALUSrc = 2'd1; ExtOp = 1'b1; end
      OP_LL:    begin legal = LLSC_EN; ALUSrc = 2'd1; ExtOp = 1'b1; MemToReg = 2'd1; end
      OP_SC:    begin legal = LLSC_EN; ALUSrc = 2'd1; ExtOp = 1'b1; MemToReg = 2'd3; end
      OP_J:     legal = 1'b1;
      OP_JAL:   begin legal = 1'b1; RegDst = 2'd2; MemToReg = 2'd2; end
      OP_HALT:  legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

  // ------------------------------------------------- next state / strobes
  always_comb begin
    state_d = state_q;
    iREN    = 1'b0;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    IRWr    = 1'b0;
    PCWr    = 1'b0;
    RegWr   = 1'b0;
    PCSrc   = PC_SEQ;
    case (state_q)
      S_FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt)     state_d = S_HALT;
        else if (!legal) state_d = S_FETCH;
        else if (is_j) begin
          PCWr    = 1'b1;
          PCSrc   = PC_J;
          state_d = S_FETCH;
        end else if (is_jr) begin
          PCWr    = 1'b1;
          PCSrc   = PC_JR;
          state_d = S_FETCH;
        end else if (is_jal) state_d = S_WB;
        else                 state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_beq || is_bne) begin
          if (branch_taken) begin
            PCWr  = 1'b1;
            PCSrc = PC_BR;
          end
          state_d = S_FETCH;
        end else if (is_mem) state_d = S_MEM;
        else                 state_d = S_WB;
      end
      S_MEM: begin
        if (is_lw || is_ll) begin
          dREN = 1'b1;
          if (dhit) state_d = S_WB;
        end else if (is_sw) begin
          dWEN = 1'b1;
          if (dhit) state_d = S_FETCH;
        end else if (is_sc) begin
          dWEN = sc_armed;
          if (sc_done) state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        RegWr = 1'b1;
        // JAL writes the link register and redirects the PC in one cycle;
        // PC already holds PC+4 from FETCH, which is the link value.
        if (is_jal) begin
          PCWr  = 1'b1;
          PCSrc = PC_J;
        end
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Requests and strobes must drop the moment reset asserts, not at the
    // next edge, so they are gated by nRST directly.
    if (!nRST) begin
      iREN  = 1'b0;
      dREN  = 1'b0;
      dWEN  = 1'b0;
      IRWr  = 1'b0;
      PCWr  = 1'b0;
      RegWr = 1'b0;
    end
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_FETCH;
      ir       <= '0;
      link_q   <= 1'b0;
      sc_armed <= 1'b0;
    end else begin
      state_q <= state_d;
      if (IRWr) ir <= instruction;

      // SC outcome is fixed as it enters MEM; an invalidate on that same
      // edge makes it fail.
      if (state_q == S_EXEC && is_sc) sc_armed <= link_q && !link_clear;

      // Invalidate has priority over a concurrent LL completion.
      if (!LLSC_EN || link_clear)
        link_q <= 1'b0;
      else if (state_q == S_MEM && is_ll && dhit)
        link_q <= 1'b1;
      else if (state_q == S_MEM && is_sc && sc_done)
        link_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] instruction;
  logic        ihit, dhit, alu_zf, link_clear;
  logic        iREN, dREN, dWEN, IRWr, PCWr, RegWr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] immediate;
  logic [25:0] immediate26;
  logic [1:0]  MemToReg, RegDst, ALUSrc;
  logic        ExtOp;
  logic [3:0]  ALUctr;
  logic [2:0]  PCSrc;
  logic        sc_success, link_valid, halt;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  // Hand-encoded instructions
  localparam logic [31:0] I_ADDI = 32'h2001_0005; // addi r1,r0,5
  localparam logic [31:0] I_ADD  = 32'h0022_2820; // add  r5,r1,r2
  localparam logic [31:0] I_ORI  = 32'h3426_FFFF; // ori  r6,r1,0xffff
  localparam logic [31:0] I_NOP  = 32'h0000_0000; // sll  r0,r0,0
  localparam logic [31:0] I_BNE  = 32'h1422_0003;
  localparam logic [31:0] I_BEQ  = 32'h1022_0003;
  localparam logic [31:0] I_LW   = 32'h8C23_0004; // lw r3,4(r1)
  localparam logic [31:0] I_SW   = 32'hAC23_0008; // sw r3,8(r1)
  localparam logic [31:0] I_LL   = 32'hC024_0000; // ll r4,0(r1)
  localparam logic [31:0] I_SC   = 32'hE024_0000; // sc r4,0(r1)
  localparam logic [31:0] I_J    = 32'h0800_0004;
  localparam logic [31:0] I_JR   = 32'h03E0_0008; // jr r31
  localparam logic [31:0] I_JAL  = 32'h0C00_0010;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;
  localparam logic [31:0] I_ILL  = 32'hF800_0000; // opcode 0x3E

  multicycle_control_unit #(.LLSC_EN(1'b1), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .instruction(instruction), .ihit(ihit),
    .dhit(dhit), .alu_zf(alu_zf), .link_clear(link_clear),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .IRWr(IRWr), .PCWr(PCWr),
    .RegWr(RegWr), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .immediate(immediate),
    .immediate26(immediate26), .MemToReg(MemToReg), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUctr(ALUctr), .PCSrc(PCSrc),
    .sc_success(sc_success), .link_valid(link_valid), .halt(halt),
    .state(state)
  );

  // ---------------------------------------------------- clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ----------------------------------------------------------- drivers
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one instruction fetch with `waits` ihit-low cycles first.
  task automatic fetch(input logic [31:0] instr, input int waits);
    for (int i = 0; i < waits; i++) begin
      ihit = 1'b0;
      #1;
      checks++;
      if ({state, iREN, IRWr} !== {3'd0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL fetch_wait got state=%0d iREN=%b IRWr=%b exp 0/1/0", state, iREN, IRWr);
      end
      tick();
    end
    ihit = 1'b1;
    instruction = instr;
    #1;
    checks++;
    if ({state, iREN, IRWr, PCWr, PCSrc} !== {3'd0, 1'b1, 1'b1, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL fetch_hit got state=%0d iREN=%b IRWr=%b PCWr=%b PCSrc=%0d exp 0/1/1/1/0",
               state, iREN, IRWr, PCWr, PCSrc);
    end
    tick();
    ihit = 1'b0;
    instruction = 32'hDEAD_BEEF;
  endtask

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    nRST = 1'b0; ihit = 1'b0; dhit = 1'b0; alu_zf = 1'b0; link_clear = 1'b0;
    instruction = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({state, halt, link_valid, iREN, opcode, immediate26} !== {3'd0, 1'b0, 1'b0, 1'b0, 6'd0, 26'd0}) begin
      errors++;
      $display("FAIL reset_state got state=%0d halt=%b link=%b iREN=%b op=%h imm26=%h exp all 0",
               state, halt, link_valid, iREN, opcode, immediate26);
    end
    nRST = 1'b1;
    #1;
    checks++;
    if (iREN !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_iren got %b exp 1", iREN);
    end
    tick();
  endtask

  task automatic test_addi();
    fetch(I_ADDI, 2);
    #1;
    checks++;
    if ({state, opcode, rs, rt, immediate} !== {3'd1, 6'h08, 5'd0, 5'd1, 16'd5}) begin
      errors++;
      $display("FAIL addi_decode got state=%0d op=%h rs=%0d rt=%0d imm=%h exp 1/08/0/1/0005",
               state, opcode, rs, rt, immediate);
    end
    tick();
    #1;
    checks++;
    if ({state, ALUSrc, ExtOp, ALUctr, RegWr} !== {3'd2, 2'd1, 1'b1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL addi_exec got state=%0d ALUSrc=%0d ExtOp=%b ALUctr=%0d RegWr=%b exp 2/1/1/0/0",
               state, ALUSrc, ExtOp, ALUctr, RegWr);
    end
    tick();
    #1;
    checks++;
    if ({state, RegWr, RegDst, MemToReg} !== {3'd4, 1'b1, 2'd0, 2'd0}) begin
      errors++;
      $display("FAIL addi_wb got state=%0d RegWr=%b RegDst=%0d MemToReg=%0d exp 4/1/0/0",
               state, RegWr, RegDst, MemToReg);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL addi_total_cycles got state=%0d exp 0 after 6 cycles", state);
    end
  endtask

  // ADD, ORI and NOP through EXEC/WB: {ALUSrc,ExtOp,ALUctr} and {RegDst}
  task automatic test_alu_classes();
    logic [31:0] instr_t  [3] = '{I_ADD, I_ORI, I_NOP};
    logic [6:0]  exec_t   [3] = '{{2'd0, 1'b0, 4'd0}, {2'd1, 1'b0, 4'd5}, {2'd2, 1'b0, 4'd10}};
    logic [1:0]  regdst_t [3] = '{2'd1, 2'd0, 2'd1};
    for (int k = 0; k < 3; k++) begin
      fetch(instr_t[k], 0);
      tick();                           // DECODE
      #1;
      checks++;
      if ({state, ALUSrc, ExtOp, ALUctr} !== {3'd2, exec_t[k]}) begin
        errors++;
        $display("FAIL alu_exec[%0d] got state=%0d src=%0d ext=%b ctr=%0d exp %h",
                 k, state, ALUSrc, ExtOp, ALUctr, {3'd2, exec_t[k]});
      end
      tick();
      #1;
      checks++;
      if ({state, RegWr, RegDst, MemToReg} !== {3'd4, 1'b1, regdst_t[k], 2'd0}) begin
        errors++;
        $display("FAIL alu_wb[%0d] got state=%0d RegWr=%b RegDst=%0d MemToReg=%0d exp 4/1/%0d/0",
                 k, state, RegWr, RegDst, MemToReg, regdst_t[k]);
      end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [31:0] instr_t [3] = '{I_BNE, I_BEQ, I_BEQ};
    logic        zf_t    [3] = '{1'b0, 1'b0, 1'b1};
    logic        take_t  [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      fetch(instr_t[k], 0);
      tick();                           // DECODE
      alu_zf = zf_t[k];
      #1;
      checks++;
      if ({state, ALUctr, PCWr, PCSrc} !== {3'd2, 4'd2, take_t[k], (take_t[k] ? 3'd1 : 3'd0)}) begin
        errors++;
        $display("FAIL branch_exec[%0d] got state=%0d ctr=%0d PCWr=%b PCSrc=%0d exp take=%b",
                 k, state, ALUctr, PCWr, PCSrc, take_t[k]);
      end
      tick();
      alu_zf = 1'b0;
      checks++;
      if ({state, RegWr} !== {3'd0, 1'b0}) begin
        errors++;
        $display("FAIL branch_return[%0d] got state=%0d RegWr=%b exp 0/0", k, state, RegWr);
      end
    end
  endtask

  task automatic test_jumps();
    fetch(I_J, 0);
    #1;
    checks++;
    if ({state, PCWr, PCSrc} !== {3'd1, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL j_decode got state=%0d PCWr=%b PCSrc=%0d exp 1/1/2", state, PCWr, PCSrc);
    end
    tick();
    fetch(I_JR, 0);
    #1;
    checks++;
    if ({state, PCWr, PCSrc, rs} !== {3'd1, 1'b1, 3'd3, 5'd31}) begin
      errors++;
      $display("FAIL jr_decode got state=%0d PCWr=%b PCSrc=%0d rs=%0d exp 1/1/3/31", state, PCWr, PCSrc, rs);
    end
    tick();
    fetch(I_ILL, 0);
    #1;
    checks++;
    if ({state, PCWr, RegWr} !== {3'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL illegal_decode got state=%0d PCWr=%b RegWr=%b exp 1/0/0", state, PCWr, RegWr);
    end
    tick();
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL illegal_return got state=%0d exp 0", state);
    end
  endtask

  task automatic test_lw_sw();
    int dren_cycles = 0;
    fetch(I_LW, 0);
    tick();                             // DECODE
    tick();                             // EXEC
    for (int i = 0; i < 3; i++) begin
      dhit = (i == 2);
      #1;
      if (state == 3'd3 && dREN === 1'b1) dren_cycles++;
      tick();
    end
    dhit = 1'b0;
    checks++;
    if (dren_cycles !== 3) begin
      errors++;
      $display("FAIL lw_dren_cycles got %0d exp 3", dren_cycles);
    end
    #1;
    checks++;
    if ({state, RegWr, MemToReg, RegDst, dREN} !== {3'd4, 1'b1, 2'd1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL lw_wb got state=%0d RegWr=%b MemToReg=%0d RegDst=%0d dREN=%b exp 4/1/1/0/0",
               state, RegWr, MemToReg, RegDst, dREN);
    end
    tick();
    fetch(I_SW, 0);
    tick();                             // DECODE
    tick();                             // EXEC
    dhit = 1'b1;
    #1;
    checks++;
    if ({state, dWEN, dREN, RegWr} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sw_mem got state=%0d dWEN=%b dREN=%b RegWr=%b exp 3/1/0/0", state, dWEN, dREN, RegWr);
    end
    tick();
    dhit = 1'b0;
    checks++;
    if ({state, dWEN, RegWr} !== {3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sw_return got state=%0d dWEN=%b RegWr=%b exp 0/0/0", state, dWEN, RegWr);
    end
  endtask

  // LL, optional coincident link_clear on its dhit, through WB.
  task automatic run_ll(input logic clr_on_hit);
    fetch(I_LL, 0);
    tick();
    tick();
    dhit = 1'b1;
    link_clear = clr_on_hit;
    #1;
    checks++;
    if ({state, dREN} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL ll_mem got state=%0d dREN=%b exp 3/1", state, dREN);
    end
    tick();
    dhit = 1'b0;
    link_clear = 1'b0;
    #1;
    checks++;
    if ({state, link_valid, MemToReg} !== {3'd4, !clr_on_hit, 2'd1}) begin
      errors++;
      $display("FAIL ll_wb got state=%0d link=%b MemToReg=%0d exp 4/%b/1", state, link_valid, MemToReg, !clr_on_hit);
    end
    tick();
  endtask

  task automatic test_llsc_ok();
    run_ll(1'b0);
    fetch(I_SC, 0);
    tick();
    tick();
    dhit = 1'b1;
    #1;
    checks++;
    if ({state, dWEN} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL sc_ok_mem got state=%0d dWEN=%b exp 3/1", state, dWEN);
    end
    tick();
    dhit = 1'b0;
    #1;
    checks++;
    if ({state, sc_success, MemToReg, RegWr, link_valid} !== {3'd4, 1'b1, 2'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sc_ok_wb got state=%0d sc=%b MemToReg=%0d RegWr=%b link=%b exp 4/1/3/1/0",
               state, sc_success, MemToReg, RegWr, link_valid);
    end
    tick();
  endtask

  task automatic test_llsc_fail();
    run_ll(1'b1);                       // clear wins over LL dhit
    run_ll(1'b0);
    link_clear = 1'b1;
    tick();
    link_clear = 1'b0;
    #1;
    checks++;
    if (link_valid !== 1'b0) begin
      errors++;
      $display("FAIL link_clear_pulse got link=%b exp 0", link_valid);
    end
    fetch(I_SC, 0);
    tick();
    tick();
    #1;
    checks++;
    if ({state, dWEN, dREN} !== {3'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sc_fail_mem got state=%0d dWEN=%b dREN=%b exp 3/0/0", state, dWEN, dREN);
    end
    tick();
    #1;
    checks++;
    if ({state, sc_success, MemToReg, RegWr} !== {3'd4, 1'b0, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL sc_fail_wb got state=%0d sc=%b MemToReg=%0d RegWr=%b exp 4/0/3/1",
               state, sc_success, MemToReg, RegWr);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    fetch(I_LW, 0);
    tick();
    tick();
    #1;
    checks++;
    if ({state, dREN} !== {3'd3, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre got state=%0d dREN=%b exp 3/1", state, dREN);
    end
    nRST = 1'b0;
    #1;
    checks++;
    if ({state, dREN, iREN} !== {3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got state=%0d dREN=%b iREN=%b exp 0/0/0", state, dREN, iREN);
    end
    tick();
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_jal_halt();
    fetch(I_JAL, 0);
    tick();                             // DECODE
    #1;
    checks++;
    if ({state, RegWr, RegDst, MemToReg, PCWr, PCSrc} !== {3'd4, 1'b1, 2'd2, 2'd2, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL jal_wb got state=%0d RegWr=%b RegDst=%0d MemToReg=%0d PCWr=%b PCSrc=%0d exp 4/1/2/2/1/2",
               state, RegWr, RegDst, MemToReg, PCWr, PCSrc);
    end
    tick();
    fetch(I_HALT, 0);
    tick();                             // DECODE -> HALT
    for (int i = 0; i < 3; i++) begin
      ihit = 1'b1;
      instruction = I_ADDI;
      #1;
      checks++;
      if ({state, halt, iREN, IRWr, PCWr, RegWr} !== {3'd5, 1'b1, 4'b0000}) begin
        errors++;
        $display("FAIL halt_hold[%0d] got state=%0d halt=%b iREN=%b IRWr=%b PCWr=%b RegWr=%b exp 5/1/0/0/0/0",
                 i, state, halt, iREN, IRWr, PCWr, RegWr);
      end
      tick();
    end
    ihit = 1'b0;
    nRST = 1'b0;
    #1;
    checks++;
    if ({state, halt} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL halt_reset got state=%0d halt=%b exp 0/0", state, halt);
    end
    tick();
    nRST = 1'b1;
    tick();
  endtask

  // ----------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_addi();
    test_alu_classes();
    test_branch();
    test_jumps();
    test_lw_sw();
    test_llsc_ok();
    test_llsc_fail();
    test_reset_mid();
    test_jal_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
